hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Scoreboard-based hazard controller for the 5-stage MIPS core.
//  - Tracks GPR writes still owed by long-latency producers (loads under a
//    multi-cycle memory, MDU, CP0 reads) in per-register pending counters.
//  - Stalls IF/ID on true RAW dependencies and bubbles EX.
//  - Sequences exception flushes around memory stalls.
//  Single-cycle forwarding stays in the datapath; this block covers only multi-cycle producers.
// PARAMETERS
//  AW          5    register address width; NREG = 2**AW, register 0 never tracked
//  CNT_W       2    pending-counter width per register; max 2**CNT_W-1 outstanding writes per register
//  STALL_LIMIT 255  consecutive hazard-stall cycles before deadlock_o fires (fits 8 bits)
// PORTS
//  clk          in   1   core clock, all state on rising edge
//  resetn       in   1   asynchronous active-low reset
//  id_valid     in   1   ID holds a valid instruction
//  id_rs        in   AW  ID source register A
//  id_rs_used   in   1   instruction reads id_rs
//  id_rt        in   AW  ID source register B
//  id_rt_used   in   1   instruction reads id_rt
//  id_we        in   1   instruction writes a GPR
//  id_wreg      in   AW  destination GPR
//  id_long      in   1   result comes from a long-latency producer
//  wb_long      in   1   a long-latency result is written or forwardable this cycle
//  wb_long_reg  in   AW  register retired by wb_long
//  mem_stall    in   1   data or instruction memory is stalling the whole pipe
//  except_m     in   1   exception taken in MEM
//  stall_f      out  1   hold PC
//  stall_d      out  1   hold IF/ID
//  flush_e      out  1   insert a bubble into ID/EX
//  flush_all    out  1   flush the D/E/M/W pipeline registers
//  cancel_long  out  1   abort in-flight long-latency ops; one-cycle pulse
//  pend_any     out  1   some counter is nonzero
//  deadlock_o   out  1   sticky: stall watchdog expired
// BEHAVIOUR
//  Reset: all counters = 0, FSM = RUN, stall_cnt = 0, every output = 0.
//  Hazard (combinational):
//    haz = id_valid & ((id_rs_used & id_rs!=0 & pend[id_rs]!=0) | (id_rt_used & id_rt!=0 & pend[id_rt]!=0)
//          | (id_we & id_long & id_wreg!=0 & pend[id_wreg]==max)).
//    The last term is a saturation stall; a counter never wraps.
//  Issue: iss = id_valid & ~haz & ~mem_stall & state==RUN & ~except_m.
//    Increment pend[id_wreg] when iss & id_we & id_long & id_wreg!=0.
//  Retire: decrement pend[wb_long_reg] when wb_long & wb_long_reg!=0, mem_stall notwithstanding.
//    Same-register increment and decrement in one cycle: net unchanged.
//    Decrement of a zero counter: stays 0 (bench flags it as an error).
//  FSM states RUN, FLUSH, PEND_FLUSH:
//    RUN: except_m & ~mem_stall -> FLUSH; except_m & mem_stall -> PEND_FLUSH.
//    PEND_FLUSH: wait while mem_stall, then -> FLUSH. The exception is latched, so except_m may drop.
//    FLUSH: one cycle -> RUN. flush_all=1, cancel_long=1, all counters cleared to 0.
//      Clear wins over a same-cycle wb_long.
//  Outputs in RUN:
//    stall_f = stall_d = mem_stall | haz
//    flush_e = haz & ~mem_stall
//  In PEND_FLUSH: stall_f = stall_d = 1, flush_e = 0.
//  In FLUSH: stall_f = 0 so the PC loads the handler; stall_d = 0; flush_e = 0; flush_all = 1.
//  Latency: a consumer in ID issues in the cycle after the wb_long that zeroes its counter.
//  Watchdog: stall_cnt increments on each RUN cycle with haz & ~mem_stall.
//    It clears on any non-haz cycle or on FLUSH.
//    At STALL_LIMIT, deadlock_o sets and holds until resetn.
//  Reset asserted mid-operation: immediate return to reset values, pending flush discarded.
// TESTING
//  T1 Load to $8 (id_long), next instruction reads $8:
//     stall_d=1 and flush_e=1 for each cycle until wb_long with reg 8; issue on the following cycle, pend[8] back to 0.
//  T2 Three long writes to $9 with CNT_W=2, no retire:
//     the 4th writer to $9 stalls on saturation; one wb_long to $9 releases it next cycle.
//  T3 Same cycle: issue a long write to $5 and wb_long to $5 with pend[5]=1:
//     pend[5] stays 1; reads of $5 still stall.
//  T4 except_m while mem_stall=1 for 3 cycles:
//     PEND_FLUSH with stall_f=1 for 3 cycles, then one FLUSH cycle with flush_all=1, cancel_long=1, all pend=0, stall_f=0.
//  T5 Reads with id_rs=0 or id_rs_used=0 against nonzero counters: no stall.
//     Writes to $0 never change any counter.
//  T6 Hazard held, STALL_LIMIT=4, no wb_long:
//     deadlock_o rises after 4 stall cycles and stays set through a FLUSH until resetn is asserted low.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Scoreboard for GPR writes owed by long-latency producers; stalls ID on RAW/saturation, sequences exception flushes.
// Combinational stall/flush outputs from registered state; a consumer issues the cycle after its last retiring wb_long.
module hazard_scoreboard #(
   parameter int AW          = 5,
   parameter int CNT_W       = 2,
   parameter int STALL_LIMIT = 255
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic          id_rs_used,
   input  logic [AW-1:0] id_rt,
   input  logic          id_rt_used,
   input  logic          id_we,
   input  logic [AW-1:0] id_wreg,
   input  logic          id_long,
   input  logic          wb_long,
   input  logic [AW-1:0] wb_long_reg,
   input  logic          mem_stall,
   input  logic          except_m,
   output logic          stall_f,
   output logic          stall_d,
   output logic          flush_e,
   output logic          flush_all,
   output logic          cancel_long,
   output logic          pend_any,
   output logic          deadlock_o
);

   localparam int NREG = 2**AW;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0] LIMIT    = 8'(STALL_LIMIT);
   localparam logic [7:0] LIMIT_M1 = 8'(STALL_LIMIT - 1);

   typedef enum logic [1:0] {RUN, FLUSH, PEND_FLUSH} state_t;

   state_t stateQ, stateD;
   logic [CNT_W-1:0] pend [NREG];
   logic [7:0] stallCnt;
   logic deadlockQ;
   logic rsHaz, rtHaz, satHaz, haz, iss, incEn, decEn, stallInc;

   always_comb begin
      rsHaz    = id_rs_used && (id_rs != '0) && (pend[id_rs] != '0);
      rtHaz    = id_rt_used && (id_rt != '0) && (pend[id_rt] != '0);
      // A full counter cannot accept another owed write, so the writer waits.
      satHaz   = id_we && id_long && (id_wreg != '0) && (pend[id_wreg] == CNT_MAX);
      haz      = id_valid && (rsHaz || rtHaz || satHaz);
      iss      = id_valid && !haz && !mem_stall && (stateQ == RUN) && !except_m;
      incEn    = iss && id_we && id_long && (id_wreg != '0);
      decEn    = wb_long && (wb_long_reg != '0);
      stallInc = (stateQ == RUN) && haz && !mem_stall;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) pend[i] <= '0;
      end else if (stateQ == FLUSH) begin
         for (int i = 0; i < NREG; i++) pend[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (incEn && (id_wreg == AW'(i)) && !(decEn && (wb_long_reg == AW'(i))))
               pend[i] <= pend[i] + CNT_W'(1);
            else if (decEn && (wb_long_reg == AW'(i)) && !(incEn && (id_wreg == AW'(i)))
                     && (pend[i] != '0))
               pend[i] <= pend[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      pend_any = 1'b0;
      for (int i = 1; i < NREG; i++)
         if (pend[i] != '0) pend_any = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) stateQ <= RUN;
      else         stateQ <= stateD;
   end

   always_comb begin
      stateD      = stateQ;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_e     = 1'b0;
      flush_all   = 1'b0;
      cancel_long = 1'b0;
      case (stateQ)
         RUN: begin
            stall_f = mem_stall || haz;
            stall_d = mem_stall || haz;
            flush_e = haz && !mem_stall;
            if (except_m) stateD = mem_stall ? PEND_FLUSH : FLUSH;
         end
         PEND_FLUSH: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            if (!mem_stall) stateD = FLUSH;
         end
         FLUSH: begin
            flush_all   = 1'b1;
            cancel_long = 1'b1;
            stateD      = RUN;
         end
         default: stateD = RUN;
      endcase
   end

   // Counter saturates at the limit so a long stall cannot wrap it back to zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stallCnt  <= '0;
         deadlockQ <= 1'b0;
      end else if ((stateQ == FLUSH) || !haz) begin
         stallCnt <= '0;
      end else if (stallInc) begin
         if (stallCnt != LIMIT) stallCnt <= stallCnt + 8'(1);
         if (stallCnt >= LIMIT_M1) deadlockQ <= 1'b1;
      end
   end

   assign deadlock_o = deadlockQ;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table plus hand-written flush/watchdog/reset sequences.
module tb_hazard_scoreboard;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic id_valid, id_rs_used, id_rt_used, id_we, id_long, wb_long, mem_stall, except_m;
   logic [AW-1:0] id_rs, id_rt, id_wreg, wb_long_reg;
   logic stall_f, stall_d, flush_e, flush_all, cancel_long, pend_any, deadlock_o;

   always #5 clk = ~clk;

   hazard_scoreboard #(.AW(AW), .CNT_W(2), .STALL_LIMIT(4)) dut (
      .clk(clk), .resetn(resetn),
      .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_we(id_we), .id_wreg(id_wreg), .id_long(id_long),
      .wb_long(wb_long), .wb_long_reg(wb_long_reg),
      .mem_stall(mem_stall), .except_m(except_m),
      .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .flush_all(flush_all),
      .cancel_long(cancel_long), .pend_any(pend_any), .deadlock_o(deadlock_o)
   );

   typedef struct packed {
      logic vld; logic [AW-1:0] rs; logic rsU; logic [AW-1:0] rt; logic rtU;
      logic we; logic [AW-1:0] wreg; logic lng; logic wbL; logic [AW-1:0] wbReg;
      logic ms; logic ex; logic [6:0] exp;   // exp = {sf, sd, fe, fa, cl, pa, dl}
   } vec_t;

   vec_t tbl[$];
   string tblNm[$];
   logic [6:0] expQ[$];
   string nameQ[$];
   int nCmp = 0;
   int nBad = 0;

   function automatic vec_t mkv(input int vld, input int rs, input int rsU, input int rt, input int rtU,
                                input int we, input int wreg, input int lng, input int wbL, input int wbReg,
                                input int ms, input int ex, input logic [6:0] exp);
      vec_t v;
      v.vld = 1'(vld); v.rs = AW'(rs); v.rsU = 1'(rsU); v.rt = AW'(rt); v.rtU = 1'(rtU);
      v.we = 1'(we); v.wreg = AW'(wreg); v.lng = 1'(lng); v.wbL = 1'(wbL); v.wbReg = AW'(wbReg);
      v.ms = 1'(ms); v.ex = 1'(ex); v.exp = exp;
      return v;
   endfunction

   task automatic add(input string nm, input vec_t v);
      tbl.push_back(v);
      tblNm.push_back(nm);
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.vld; id_rs = v.rs; id_rs_used = v.rsU; id_rt = v.rt; id_rt_used = v.rtU;
      id_we = v.we; id_wreg = v.wreg; id_long = v.lng; wb_long = v.wbL; wb_long_reg = v.wbReg;
      mem_stall = v.ms; except_m = v.ex;
   endtask

   task automatic check();
      logic [6:0] act, e;
      string n;
      nCmp++;
      if (expQ.size() == 0) begin
         nBad++;
         $display("FAIL scoreboard_empty: no expected record queued");
         return;
      end
      e = expQ.pop_front();
      n = nameQ.pop_front();
      act = {stall_f, stall_d, flush_e, flush_all, cancel_long, pend_any, deadlock_o};
      if (act !== e) begin
         nBad++;
         $display("FAIL %s: got %b want %b (sf sd fe fa cl pa dl)", n, act, e);
      end
   endtask

   // Called at posedge+1: drive, queue expectation, compare at negedge, move to next posedge+1.
   task automatic apply(input string nm, input vec_t v);
      drive(v);
      expQ.push_back(v.exp);
      nameQ.push_back(nm);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   task automatic resetCheck(input string nm);
      drive(mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0));
      resetn = 1'b0;
      expQ.push_back(7'b0000000);
      nameQ.push_back(nm);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      // T1 load-use on $8
      add("t1_ld",    mkv(1,1,1,0,0,1,8,1,0,0,0,0,7'b0000000));
      add("t1_st1",   mkv(1,8,1,0,0,1,10,0,0,0,0,0,7'b1110010));
      add("t1_st2",   mkv(1,8,1,0,0,1,10,0,0,0,0,0,7'b1110010));
      add("t1_wb",    mkv(1,8,1,0,0,1,10,0,1,8,0,0,7'b1110010));
      add("t1_iss",   mkv(1,8,1,0,0,1,10,0,0,0,0,0,7'b0000000));
      // T2 saturation on $9
      add("t2_w1",    mkv(1,0,0,0,0,1,9,1,0,0,0,0,7'b0000000));
      add("t2_w2",    mkv(1,0,0,0,0,1,9,1,0,0,0,0,7'b0000010));
      add("t2_w3",    mkv(1,0,0,0,0,1,9,1,0,0,0,0,7'b0000010));
      add("t2_sat",   mkv(1,0,0,0,0,1,9,1,0,0,0,0,7'b1110010));
      add("t2_satwb", mkv(1,0,0,0,0,1,9,1,1,9,0,0,7'b1110010));
      add("t2_rel",   mkv(1,0,0,0,0,1,9,1,0,0,0,0,7'b0000010));
      add("t2_dr1",   mkv(0,0,0,0,0,0,0,0,1,9,0,0,7'b0000010));
      add("t2_dr2",   mkv(0,0,0,0,0,0,0,0,1,9,0,0,7'b0000010));
      add("t2_dr3",   mkv(0,0,0,0,0,0,0,0,1,9,0,0,7'b0000010));
      // T3 same-cycle inc/dec on $5
      add("t3_w",     mkv(1,0,0,0,0,1,5,1,0,0,0,0,7'b0000000));
      add("t3_same",  mkv(1,0,0,0,0,1,5,1,1,5,0,0,7'b0000010));
      add("t3_rd",    mkv(1,5,1,0,0,0,0,0,0,0,0,0,7'b1110010));
      add("t3_rdwb",  mkv(1,5,1,0,0,0,0,0,1,5,0,0,7'b1110010));
      add("t3_iss",   mkv(1,5,1,0,0,0,0,0,0,0,0,0,7'b0000000));
      // T5 unused/zero sources and $0 writes
      add("t5_w7",    mkv(1,0,0,0,0,1,7,1,0,0,0,0,7'b0000000));
      add("t5_rs0",   mkv(1,0,1,7,0,0,0,0,0,0,0,0,7'b0000010));
      add("t5_unus",  mkv(1,7,0,0,1,0,0,0,0,0,0,0,7'b0000010));
      add("t5_wr0",   mkv(1,0,0,0,0,1,0,1,1,0,0,0,7'b0000010));
      add("t5_rt7",   mkv(1,0,0,7,1,0,0,0,0,0,0,0,7'b1110010));
      add("t5_wb7",   mkv(0,0,0,0,0,0,0,0,1,7,0,0,7'b0000010));
      add("t5_idle",  mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      // mem_stall interaction: no flush_e, retire still counts, no issue
      add("ms_w3",    mkv(1,0,0,0,0,1,3,1,0,0,0,0,7'b0000000));
      add("ms_rd",    mkv(1,3,1,0,0,0,0,0,0,0,1,0,7'b1100010));
      add("ms_wb",    mkv(0,0,0,0,0,0,0,0,1,3,1,0,7'b1100010));
      add("ms_idle",  mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      add("ms_noiss", mkv(1,0,0,0,0,1,4,1,0,0,1,0,7'b1100000));
      add("ms_chk",   mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      // retire against an empty counter must not wrap
      add("z_dec",    mkv(0,0,0,0,0,0,0,0,1,20,0,0,7'b0000000));
      add("z_w",      mkv(1,0,0,0,0,1,20,1,0,0,0,0,7'b0000000));
      add("z_wb",     mkv(0,0,0,0,0,0,0,0,1,20,0,0,7'b0000010));
      add("z_chk",    mkv(1,20,1,0,0,0,0,0,0,0,0,0,7'b0000000));

      drive(mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0));
      repeat (2) @(posedge clk);
      #1;
      resetCheck("reset");

      for (int i = 0; i < tbl.size(); i++) apply(tblNm[i], tbl[i]);

      // T4 exception under a 3-cycle memory stall, pend[6]=2 before the flush
      apply("t4_w6a",  mkv(1,0,0,0,0,1,6,1,0,0,0,0,7'b0000000));
      apply("t4_w6b",  mkv(1,0,0,0,0,1,6,1,0,0,0,0,7'b0000010));
      apply("t4_exc",  mkv(0,0,0,0,0,0,0,0,0,0,1,1,7'b1100010));
      apply("t4_pf1",  mkv(0,0,0,0,0,0,0,0,0,0,1,0,7'b1100010));
      apply("t4_pf2",  mkv(1,6,1,0,0,0,0,0,0,0,1,0,7'b1100010));
      apply("t4_pf3",  mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b1100010));
      apply("t4_flush",mkv(1,6,1,0,0,0,0,0,1,6,0,0,7'b0001110));
      apply("t4_after",mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      apply("t4_rd6",  mkv(1,6,1,0,0,0,0,0,0,0,0,0,7'b0000000));

      // T6 watchdog with STALL_LIMIT=4, sticky through FLUSH
      apply("t6_w12",  mkv(1,0,0,0,0,1,12,1,0,0,0,0,7'b0000000));
      for (int i = 0; i < 4; i++)
         apply($sformatf("t6_st%0d", i), mkv(1,12,1,0,0,0,0,0,0,0,0,0,7'b1110010));
      apply("t6_dead", mkv(1,12,1,0,0,0,0,0,0,0,0,0,7'b1110011));
      apply("t6_exc",  mkv(1,12,1,0,0,0,0,0,0,0,0,1,7'b1110011));
      apply("t6_flush",mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0001111));
      apply("t6_hold", mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000001));

      // reset mid-operation discards a pending flush and the deadlock flag
      apply("rs_w13",  mkv(1,0,0,0,0,1,13,1,0,0,0,0,7'b0000001));
      apply("rs_exc",  mkv(0,0,0,0,0,0,0,0,0,0,1,1,7'b1100011));
      resetCheck("rs_mid");
      apply("rs_idle1",mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      apply("rs_idle2",mkv(0,0,0,0,0,0,0,0,0,0,0,0,7'b0000000));
      apply("rs_rd13", mkv(1,13,1,0,0,0,0,0,0,0,0,0,7'b0000000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
